// File: rtl/mix_state_reader.sv
// Snapshot reader for the mixing-state engine: captures NWORDS words in one
// handshake, streams them out in index order and folds them into a rotate-XOR signature.
module mix_state_reader #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 8,
  parameter int ROT    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      snap_valid,
  output logic                      snap_ready,
  input  logic [WIDTH*NWORDS-1:0]   snap_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NWORDS)-1:0] out_index,
  output logic                      out_last,
  output logic [WIDTH-1:0]          sig,
  output logic                      sig_valid,
  output logic [15:0]               snap_count
);

  localparam int IW = $clog2(NWORDS);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  // Lossless left rotation by ROT bits.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
    return (v << ROT) | (v >> (WIDTH - ROT));
  endfunction

  logic [0:0]       state_r;
  logic [WIDTH-1:0] buf_r [NWORDS];
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] acc_r;
  logic             snap_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic [WIDTH-1:0] sig_r;
  logic             sig_valid_r;
  logic [15:0]      snap_count_r;

  logic             cap_s;
  logic             adv_s;
  logic [IW-1:0]    nxt_idx_s;
  logic [WIDTH-1:0] acc_next_s;

  // Handshake decode and next-accumulator value.
  always_comb begin
    cap_s      = snap_valid & snap_ready_r & (state_r == ST_IDLE);
    adv_s      = out_valid_r & out_ready & (state_r == ST_STREAM);
    nxt_idx_s  = idx_r + IW'(1);
    acc_next_s = rotl(acc_r) ^ out_data_r;
  end

  // Capture / stream state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      for (int k = 0; k < NWORDS; k++) buf_r[k] <= '0;
      idx_r        <= '0;
      acc_r        <= '0;
      snap_ready_r <= 1'b1;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_last_r   <= 1'b0;
      sig_r        <= '0;
      sig_valid_r  <= 1'b0;
      snap_count_r <= 16'd0;
    end else begin
      sig_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cap_s) begin
            for (int k = 0; k < NWORDS; k++) buf_r[k] <= snap_data[k*WIDTH +: WIDTH];
            idx_r        <= '0;
            acc_r        <= '0;
            snap_ready_r <= 1'b0;
            out_valid_r  <= 1'b1;
            out_data_r   <= snap_data[WIDTH-1:0];
            out_last_r   <= 1'b0;
            state_r      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (adv_s) begin
            acc_r <= acc_next_s;
            if (out_last_r) begin
              // Final word consumed: publish signature and reopen for capture.
              state_r      <= ST_IDLE;
              idx_r        <= '0;
              snap_ready_r <= 1'b1;
              out_valid_r  <= 1'b0;
              out_data_r   <= '0;
              out_last_r   <= 1'b0;
              sig_r        <= acc_next_s;
              sig_valid_r  <= 1'b1;
              snap_count_r <= snap_count_r + 16'd1;
            end else begin
              idx_r      <= nxt_idx_s;
              out_data_r <= buf_r[nxt_idx_s];
              out_last_r <= (nxt_idx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          snap_ready_r <= 1'b1;
          out_valid_r  <= 1'b0;
          out_last_r   <= 1'b0;
        end
      endcase
    end
  end

  assign snap_ready = snap_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_index  = idx_r;
  assign out_last   = out_last_r;
  assign sig        = sig_r;
  assign sig_valid  = sig_valid_r;
  assign snap_count = snap_count_r;

endmodule

// File: tb/tb_mix_state_reader.sv
// Directed plus randomized bench for mix_state_reader against a simple
// array-based signature model.
module tb_mix_state_reader;

  localparam int W  = 32;
  localparam int NW = 8;
  localparam int R  = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            snap_valid = 1'b0;
  logic            snap_ready;
  logic [W*NW-1:0] snap_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [2:0]      out_index;
  logic            out_last;
  logic [W-1:0]    sig;
  logic            sig_valid;
  logic [15:0]     snap_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] cur_w [NW];
  logic [W-1:0] nxt_w [NW];
  logic [W-1:0] exp_sig = '0;
  int           exp_count = 0;
  int           last_cycles = 0;

  mix_state_reader #(.WIDTH(W), .NWORDS(NW), .ROT(R)) dut (
    .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_data(snap_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .sig(sig), .sig_valid(sig_valid), .snap_count(snap_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference signature: fold words with a 64-bit doubled-value rotate.
  function automatic logic [W-1:0] model_sig(input logic [W-1:0] w [NW]);
    logic [W-1:0] a;
    logic [2*W-1:0] d;
    a = '0;
    for (int k = 0; k < NW; k++) begin
      d = {a, a};
      d = d >> (W - R);
      a = d[W-1:0] ^ w[k];
    end
    return a;
  endfunction

  function automatic logic [W*NW-1:0] pack(input logic [W-1:0] w [NW]);
    logic [W*NW-1:0] p;
    for (int k = 0; k < NW; k++) p[k*W +: W] = w[k];
    return p;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_snap_ready"}, W'(snap_ready), 32'd1);
    chk({tag, "_out_valid"}, W'(out_valid), 32'd0);
    chk({tag, "_out_last"}, W'(out_last), 32'd0);
    chk({tag, "_sig_valid"}, W'(sig_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_index"}, W'(out_index), 32'd0);
    chk({tag, "_sig"}, sig, 32'd0);
    chk({tag, "_snap_count"}, W'(snap_count), 32'd0);
  endtask

  // Offer cur_w while idle; afterwards scramble snap_data to prove it is ignored.
  task automatic capture();
    snap_data  = pack(cur_w);
    snap_valid = 1'b1;
    chk("cap_snap_ready", W'(snap_ready), 32'd1);
    tick();
    snap_valid = 1'b0;
    snap_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Drain cur_w. mode 0: always ready, 1: toggling, 2: random with random snap inputs.
  // chain: offer nxt_w in the signature cycle. stop_at: return once this index is shown.
  task automatic stream(input int mode, input bit chain, input int stop_at);
    int k;
    int c;
    bit rdy;
    k = 0;
    c = 0;
    while (k < NW && c < 200) begin
      if (k == stop_at) return;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (mode == 2) begin
        snap_valid = 1'($urandom_range(0, 1));
        snap_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      chk("st_out_valid", W'(out_valid), 32'd1);
      chk("st_snap_ready", W'(snap_ready), 32'd0);
      chk("st_out_data", out_data, cur_w[k]);
      chk("st_out_index", W'(out_index), W'(k));
      chk("st_out_last", W'(out_last), W'(k == NW - 1));
      chk("st_sig_valid", W'(sig_valid), 32'd0);
      tick();
      if (rdy) k++;
      c++;
    end
    last_cycles = c;
    chk("st_bounded", W'(k), W'(NW));
    exp_sig = model_sig(cur_w);
    exp_count = (exp_count + 1) % 65536;
    out_ready = 1'b0;
    if (chain) begin
      snap_valid = 1'b1;
      snap_data  = pack(nxt_w);
    end else begin
      snap_valid = 1'b0;
    end
    chk("end_sig_valid", W'(sig_valid), 32'd1);
    chk("end_sig", sig, exp_sig);
    chk("end_snap_count", W'(snap_count), W'(exp_count));
    chk("end_snap_ready", W'(snap_ready), 32'd1);
    chk("end_out_valid", W'(out_valid), 32'd0);
    tick();
    snap_valid = 1'b0;
    chk("post_sig_valid", W'(sig_valid), 32'd0);
    chk("post_sig_hold", sig, exp_sig);
    chk("post_out_valid", W'(out_valid), W'(chain));
  endtask

  initial begin
    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_low");
    rst_n = 1'b1;
    tick();
    check_reset_state("rst_idle");

    // Words k = k, full throughput; known signature 1144132807.
    for (int k = 0; k < NW; k++) cur_w[k] = W'(k);
    capture();
    stream(0, 1'b0, NW);
    chk("seq_sig_const", sig, 32'd1144132807);
    chk("seq_cycles", W'(last_cycles), 32'd8);

    // Same words with out_ready toggling.
    capture();
    stream(1, 1'b0, NW);
    chk("tog_sig_const", sig, 32'd1144132807);
    chk("tog_cycles", W'(last_cycles), 32'd15);

    // Back-to-back: all ones then all zeros, second capture in the sig_valid cycle.
    for (int k = 0; k < NW; k++) begin
      cur_w[k] = 32'hFFFF_FFFF;
      nxt_w[k] = 32'h0000_0000;
    end
    capture();
    snap_valid = 1'b1;
    snap_data  = pack(nxt_w);
    stream(0, 1'b1, NW);
    for (int k = 0; k < NW; k++) cur_w[k] = nxt_w[k];
    stream(0, 1'b0, NW);
    chk("b2b_count", W'(snap_count), 32'd4);

    // Randomized snapshots with random stalls, snap_valid and snap_data noise.
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NW; k++) cur_w[k] = $urandom;
      capture();
      stream(2, 1'b0, NW);
    end

    // Reset while index 4 is presented.
    for (int k = 0; k < NW; k++) cur_w[k] = $urandom;
    capture();
    stream(0, 1'b0, 4);
    chk("pre_rst_index", W'(out_index), 32'd4);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    tick();
    check_reset_state("after_rst");

    // Fresh snapshot after reset starts from index 0.
    for (int k = 0; k < NW; k++) cur_w[k] = $urandom;
    capture();
    stream(2, 1'b0, NW);
    chk("final_count", W'(snap_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_state_reader.md
Name: mix_state_reader

Overview:
- Read-side companion to the 8-lane mixing-state engine. Takes one parallel snapshot of the NWORDS state words through a valid/ready handshake.
- Streams the captured words out one per handshake, index order 0..NWORDS-1.
- Folds each streamed word into a rotate-XOR signature. Pulses the final signature after the last word.
- Sits between the mixing core and the trace/compare logic in the simulation benchmark harness.

Parameters:
- WIDTH, 32, bits per state word.
- NWORDS, 8, words per snapshot (power of two, 2..256).
- ROT, 5, left-rotate amount per signature step (1..WIDTH-1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- snap_valid  in  1  snapshot offered
- snap_ready  out  1  reader can accept a snapshot
- snap_data  in  WIDTH*NWORDS  word k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  streamed word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  WIDTH  current word
- out_index  out  log2(NWORDS)  index of current word
- out_last  out  1  current word is index NWORDS-1
- sig  out  WIDTH  signature of the last completed snapshot
- sig_valid  out  1  one-cycle pulse when sig is updated
- snap_count  out  16  number of completed snapshots, wraps at 2^16

Behaviour:
- Reset (async assert, sync release):
  - State IDLE. Buffer, index, accumulator, sig and snap_count are 0.
  - snap_ready=1. out_valid, out_last, sig_valid are 0. out_data and out_index are 0.
- States: IDLE, STREAM.
- IDLE:
  - snap_ready=1, out_valid=0.
  - A handshake (snap_valid & snap_ready) at edge N does all of the following: captures all words, sets index=0, clears the accumulator to 0, moves to STREAM.
- STREAM:
  - snap_ready=0, out_valid=1, out_data=buffer[index], out_index=index, out_last=(index==NWORDS-1).
  - The first word is visible in the cycle after the capture edge (latency 1).
  - Stall (out_ready=0): out_data, out_index and out_last stay stable; nothing advances.
  - Handshake (out_valid & out_ready): acc <= rotl(acc, ROT) ^ out_data. If not last, index+1 and the next word appears the next cycle (one word per cycle at full throughput).
- Last-word handshake:
  - Next cycle: state IDLE, sig = final acc value, sig_valid=1 for exactly one cycle, snap_count+1 (mod 2^16).
  - snap_ready is 1 in that same cycle, so a snapshot offered then is accepted. sig_valid and the new capture coexist without interaction.
- snap_data is sampled only on the capture edge. Changes while in STREAM are ignored. snap_valid while in STREAM is not accepted.
- sig holds its value until the next completed snapshot. A partially streamed snapshot never updates sig.
- Reset mid-STREAM: everything returns to reset values immediately. The partial snapshot is discarded and snap_count is not incremented.
- All arithmetic is modulo 2^WIDTH. The rotate is a pure bit rotation with no loss.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> snap_ready=1, out_valid=0, sig=0, snap_count=0.
- Snapshot words k=k (0..7), out_ready=1 always -> out_data 0,1,..,7 on 8 consecutive cycles starting 1 cycle after capture; out_last only with 7; next cycle sig=1144132807, sig_valid 1 cycle, snap_count=1.
- Same snapshot with out_ready toggling 1,0,1,0.. -> each word held during stalls; same sig=1144132807 after 15 cycles of streaming.
- Back-to-back: snap_valid held high with words all 0xFFFFFFFF then all 0 -> second capture in the sig_valid cycle; sigs 0xFFFFFFFF^... computed by model match; snap_count=2.
- rst_n pulsed low while out_index=4 -> outputs to reset values that cycle; sig stays 0; new snapshot afterwards streams from index 0.
- snap_data changed during STREAM -> streamed words equal captured values; no extra acceptance.
